lamp_switch_conditioner: RTL

//  Front-end stage that feeds water_lamp. Takes raw, bouncy cabin switches
//  (left, right, brake, door) and produces the clean level requests

---
 rtl/lamp_switch_conditioner_if.sv | 23 ++
 rtl/lamp_switch_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lamp_switch_conditioner_if.sv
// Signal bundle between the raw cabin switches and the conditioned lamp requests.
// All request outputs are level signals; the driver side owns the sw* inputs.
interface lamp_switch_conditioner_if;
    logic       swL;
    logic       swR;
    logic       swBrake;
    logic       swDoor;
    logic       rstL;
    logic       rstR;
    logic       rstBrake;
    logic       rstDoor;
    logic [2:0] turnSt;

    modport master (
        output swL, swR, swBrake, swDoor,
        input  rstL, rstR, rstBrake, rstDoor, turnSt
    );

    modport slave (
        input  swL, swR, swBrake, swDoor,
        output rstL, rstR, rstBrake, rstDoor, turnSt
    );
endinterface

// File: rtl/lamp_switch_conditioner.sv
// Synchronises and debounces four cabin switches, then resolves left/right
// into LEFT/RIGHT/HAZARD with a forced dark gap before the next turn request.
module lamp_switch_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 8
) (
    input logic                         clk,
    input logic                         rstN,
    lamp_switch_conditioner_if.slave    bus
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_HAZARD = 3'd3,
        ST_GAP    = 3'd4
    } turn_state_e;

    // Channel order: 0 left, 1 right, 2 brake, 3 door
    logic [3:0]         sw;
    logic [3:0]         s1_q, s1_d;
    logic [3:0]         s2_q, s2_d;
    logic [3:0]         stable_q, stable_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;

    turn_state_e        state_q, state_d;
    logic [GW-1:0]      gcnt_q, gcnt_d;
    logic               rst_l_q, rst_l_d;
    logic               rst_r_q, rst_r_d;
    logic               rst_brake_q, rst_brake_d;
    logic               rst_door_q, rst_door_d;

    logic               l;
    logic               r;

    assign sw = {bus.swDoor, bus.swBrake, bus.swR, bus.swL};
    assign l  = stable_q[0];
    assign r  = stable_q[1];

    always_comb begin
        s1_d     = sw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (l && r)       state_d = ST_HAZARD;
                else if (l)       state_d = ST_LEFT;
                else if (r)       state_d = ST_RIGHT;
            end
            ST_LEFT: begin
                if (l && r)       state_d = ST_HAZARD;
                else if (!l)      state_d = ST_GAP;
            end
            ST_RIGHT: begin
                if (l && r)       state_d = ST_HAZARD;
                else if (!r)      state_d = ST_GAP;
            end
            // Releasing only one side keeps hazard latched
            ST_HAZARD: begin
                if (!l && !r)     state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gcnt_q == GAP_MAX) begin
                    state_d = ST_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d  = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gcnt_d  = '0;
            end
        endcase
        if (state_d == ST_GAP && state_q != ST_GAP) gcnt_d = '0;

        rst_l_d     = (state_d == ST_LEFT)  || (state_d == ST_HAZARD);
        rst_r_d     = (state_d == ST_RIGHT) || (state_d == ST_HAZARD);
        rst_brake_d = stable_q[2];
        rst_door_d  = stable_q[3];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            gcnt_q      <= '0;
            rst_l_q     <= 1'b0;
            rst_r_q     <= 1'b0;
            rst_brake_q <= 1'b0;
            rst_door_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            rst_l_q     <= rst_l_d;
            rst_r_q     <= rst_r_d;
            rst_brake_q <= rst_brake_d;
            rst_door_q  <= rst_door_d;
        end
    end

    assign bus.rstL     = rst_l_q;
    assign bus.rstR     = rst_r_q;
    assign bus.rstBrake = rst_brake_q;
    assign bus.rstDoor  = rst_door_q;
    assign bus.turnSt   = state_q;
endmodule
